// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: latches floor calls and issues SCAN-ordered targets to the elevator controller
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  elev_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;
  state_t state, state_next;
  logic [NUM_FLOORS-1:0] sync1, sync2, prev, rise, clr;
  logic above, below;
  logic [FLOOR_W-1:0] lo, hi, tgt_next;
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    lo = '0;
    hi = '0;
    clr = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) >= current_floor) begin
        above = 1'b1;
        lo = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && FLOOR_W'(i) <= current_floor) begin
        below = 1'b1;
        hi = FLOOR_W'(i);
      end
      clr[i] = elev_idle && current_floor == FLOOR_W'(i);
    end
    rise = sync2 & ~prev;
    state_next = state == S_IDLE ? (pending == '0 ? S_IDLE : above ? S_UP : S_DOWN) :
                 state == S_UP   ? (above ? S_UP : below ? S_DOWN : S_IDLE) :
                                   (below ? S_DOWN : above ? S_UP : S_IDLE);
    tgt_next = state_next == S_UP ? lo : state_next == S_DOWN ? hi : current_floor;
  end
  // clear wins over a same-edge set: the car is already at that floor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      pending <= '0;
      state <= S_IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
    end else begin
      sync1 <= call_btn;
      sync2 <= sync1;
      prev <= sync2;
      pending <= (pending | rise) & ~clr;
      state <= state_next;
      target_floor <= tgt_next;
      target_valid <= state_next != S_IDLE;
    end
  end
  assign dir_up = state == S_UP;
endmodule
